// File: rtl/avalon_reg_bank_pkg.sv
// rtl/avalon_reg_bank_pkg.sv - shared offsets, clog2 and default ID for avalon_reg_bank
package avalon_reg_bank_pkg;

    localparam logic [31:0] DEFAULT_ID = 32'h0001_0000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int STATUS_OFS(input int n);
        return n;
    endfunction

    function automatic int MASK_OFS(input int n);
        return n + 1;
    endfunction

    function automatic int ID_OFS(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/avalon_reg_bank_be_reg.sv
// rtl/avalon_reg_bank_be_reg.sv - register with per-byte write enable
module be_reg #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   d,
    output logic [DATA_WIDTH-1:0]   q
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= RESET_VALUE;
        end else if (we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (be[i]) q[i*8 +: 8] <= d[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/avalon_reg_bank.sv
// rtl/avalon_reg_bank.sv - Avalon-MM control register bank with W1C event status and irq
module avalon_reg_bank
    import avalon_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter int                    NUM_EVENTS  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [31:0]           ID_VALUE    = DEFAULT_ID,
    localparam int                   ADDR_W      = clog2(NUM_REGS + 3)
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [ADDR_W-1:0]              address,
    input  logic                           chipselect,
    input  logic                           read,
    input  logic                           write,
    input  logic [DATA_WIDTH/8-1:0]        byteenable,
    input  logic [DATA_WIDTH-1:0]          writedata,
    output logic [DATA_WIDTH-1:0]          readdata,
    output logic                           readdatavalid,
    input  logic [NUM_EVENTS-1:0]          event_in,
    output logic                           irq,
    output logic [NUM_REGS*DATA_WIDTH-1:0] Q_export
);

    localparam logic [ADDR_W-1:0]     STATUS_A = ADDR_W'(STATUS_OFS(NUM_REGS));
    localparam logic [ADDR_W-1:0]     MASK_A   = ADDR_W'(MASK_OFS(NUM_REGS));
    localparam logic [ADDR_W-1:0]     ID_A     = ADDR_W'(ID_OFS(NUM_REGS));
    localparam logic [DATA_WIDTH-1:0] EV_MASK  = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - NUM_EVENTS);
    localparam logic [DATA_WIDTH-1:0] ID_WORD  = DATA_WIDTH'(ID_VALUE);

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] be_bits;
    logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] status_d;
    logic [DATA_WIDTH-1:0] w1c;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [NUM_EVENTS-1:0] event_q;

    assign wr_acc = chipselect & write;
    assign rd_acc = chipselect & read;
    assign rise   = DATA_WIDTH'(event_in & ~event_q);

    always_comb begin
        be_bits = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            be_bits[i*8 +: 8] = {8{byteenable[i]}};
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl
        be_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_ctrl (
            .clock (clock),
            .resetn(resetn),
            .we    (wr_acc && (address == ADDR_W'(k))),
            .be    (byteenable),
            .d     (writedata),
            .q     (ctrl_q[k])
        );
        assign Q_export[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end

    // Bits above NUM_EVENTS are forced to zero on write so the mask reads back clean.
    be_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE('0)
    ) u_mask (
        .clock (clock),
        .resetn(resetn),
        .we    (wr_acc && (address == MASK_A)),
        .be    (byteenable),
        .d     (writedata & EV_MASK),
        .q     (mask_q)
    );

    // A rise is ORed in after the clear, so set wins a same-cycle collision.
    always_comb begin
        w1c      = (wr_acc && (address == STATUS_A)) ? (writedata & be_bits) : '0;
        status_d = ((status_q & ~w1c) | rise) & EV_MASK;
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDR_W'(k)) rd_mux = ctrl_q[k];
        end
        if (address == STATUS_A) rd_mux = status_q;
        if (address == MASK_A)   rd_mux = mask_q;
        if (address == ID_A)     rd_mux = ID_WORD;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            status_q      <= '0;
            event_q       <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            irq           <= 1'b0;
        end else begin
            status_q      <= status_d;
            event_q       <= event_in;
            readdatavalid <= rd_acc;
            if (rd_acc) readdata <= rd_mux;
            irq           <= |(status_q & mask_q);
        end
    end

endmodule

// File: tb/tb_avalon_reg_bank.sv
// tb/tb_avalon_reg_bank.sv - self-checking bench for avalon_reg_bank
module tb_avalon_reg_bank;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NE = 8;
    localparam int AW = 3;
    localparam logic [31:0] ID = 32'h0001_0000;

    logic             clock = 1'b0;
    logic             resetn;
    logic [AW-1:0]    address;
    logic             chipselect;
    logic             read;
    logic             write;
    logic [DW/8-1:0]  byteenable;
    logic [DW-1:0]    writedata;
    logic [DW-1:0]    readdata;
    logic             readdatavalid;
    logic [NE-1:0]    event_in;
    logic             irq;
    logic [NR*DW-1:0] Q_export;

    always #5 clock = ~clock;

    avalon_reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_EVENTS (NE),
        .RESET_VALUE(32'h0),
        .ID_VALUE   (ID)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .event_in     (event_in),
        .irq          (irq),
        .Q_export     (Q_export)
    );

    logic [31:0]      ctrl_m [NR];
    logic [7:0]       status_m, mask_m, ev_prev;
    logic [31:0]      exp_rd;
    logic             exp_rdv, exp_irq;
    logic [NR*DW-1:0] exp_q;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a < NR)      return ctrl_m[a];
        if (a == NR)     return {24'h0, status_m};
        if (a == NR + 1) return {24'h0, mask_m};
        if (a == NR + 2) return ID;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) ctrl_m[k] = 32'h0;
        status_m = 0; mask_m = 0; ev_prev = 0;
        exp_rd = 0; exp_rdv = 0; exp_irq = 0; exp_q = '0;
    endtask

    // One bus cycle: model computes what the DUT must show after the edge, then drive.
    task automatic step(input logic cs, input logic rd, input logic wr, input int a,
                        input logic [3:0] be, input logic [31:0] d, input logic [7:0] ev);
        logic [31:0] t;
        exp_irq = |(status_m & mask_m);
        exp_rdv = cs && rd;
        if (cs && rd) exp_rd = model_read(a);
        if (cs && wr) begin
            if (a < NR) ctrl_m[a] = merge(ctrl_m[a], d, be);
            else if (a == NR) begin
                t = merge(32'h0, d, be);
                status_m = status_m & ~t[7:0];
            end else if (a == NR + 1) begin
                t = merge({24'h0, mask_m}, d, be);
                mask_m = t[7:0];
            end
        end
        status_m = status_m | (ev & ~ev_prev);
        ev_prev  = ev;
        for (int k = 0; k < NR; k++) exp_q[k*DW +: DW] = ctrl_m[k];
        chipselect = cs; read = rd; write = wr; address = AW'(a);
        byteenable = be; writedata = d; event_in = ev;
        @(posedge clock); #1;
        chipselect = 0; read = 0; write = 0;
    endtask

    task automatic wr_reg(input int a, input logic [3:0] be, input logic [31:0] d);
        step(1, 0, 1, a, be, d, event_in);
    endtask

    task automatic rd_reg(input int a);
        step(1, 1, 0, a, 4'h0, 32'h0, event_in);
    endtask

    task automatic idle(input logic [7:0] ev);
        step(0, 0, 0, 0, 4'h0, 32'h0, ev);
    endtask

    task automatic test_reset();
        resetn = 0; chipselect = 0; read = 0; write = 0; address = 0;
        byteenable = 0; writedata = 0; event_in = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got %h want 0", readdata); end
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_rdv got %b want 0", readdatavalid); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (Q_export !== {NR{32'h0}}) begin n_bad++; $display("FAIL reset_q got %h want 0", Q_export); end
        resetn = 1;
        rd_reg(NR + 2);
        n_cmp++; if (readdatavalid !== 1'b1) begin n_bad++; $display("FAIL id_rdv got %b want 1", readdatavalid); end
        n_cmp++; if (readdata !== ID) begin n_bad++; $display("FAIL id_read got %h want %h", readdata, ID); end
        idle(0);
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL id_rdv_pulse got %b want 0", readdatavalid); end
    endtask

    task automatic test_byte_enable();
        wr_reg(2, 4'b1111, 32'hDEAD_BEEF);
        wr_reg(2, 4'b0101, 32'h1234_5678);
        rd_reg(2);
        n_cmp++; if (readdata !== 32'hDE34_BE78) begin n_bad++; $display("FAIL be_read got %h want DE34BE78", readdata); end
        n_cmp++; if (Q_export[2*DW +: DW] !== 32'hDE34_BE78) begin n_bad++; $display("FAIL be_slice got %h want DE34BE78", Q_export[2*DW +: DW]); end
        n_cmp++; if (Q_export !== exp_q) begin n_bad++; $display("FAIL be_q got %h want %h", Q_export, exp_q); end
    endtask

    task automatic test_rw_same();
        wr_reg(0, 4'hF, 32'd5);
        step(1, 1, 1, 0, 4'hF, 32'd9, event_in);
        n_cmp++; if (readdata !== 32'd5) begin n_bad++; $display("FAIL rw_old got %h want 5", readdata); end
        rd_reg(0);
        n_cmp++; if (readdata !== 32'd9) begin n_bad++; $display("FAIL rw_new got %h want 9", readdata); end
    endtask

    task automatic test_event_irq();
        wr_reg(NR + 1, 4'hF, 32'h04);
        idle(8'h04);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ev_irq_early got %b want 0", irq); end
        idle(8'h00);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ev_irq_rise got %b want 1", irq); end
        rd_reg(NR);
        n_cmp++; if (readdata !== 32'h04) begin n_bad++; $display("FAIL ev_status got %h want 04", readdata); end
        wr_reg(NR, 4'hF, 32'h04);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL w1c_irq_hold got %b want 1", irq); end
        idle(8'h00);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq_drop got %b want 0", irq); end
        rd_reg(NR);
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL w1c_status got %h want 0", readdata); end
    endtask

    task automatic test_collision();
        step(1, 0, 1, NR, 4'hF, 32'h02, 8'h02);
        rd_reg(NR);
        n_cmp++; if (readdata[1] !== 1'b1) begin n_bad++; $display("FAIL coll_set got %b want 1", readdata[1]); end
        wr_reg(NR, 4'hF, 32'h02);
        rd_reg(NR);
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL held_no_reset got %h want 0", readdata); end
        idle(8'h00);
    endtask

    task automatic test_back_to_back();
        int addrs[3] = '{0, NR + 3, 1};
        for (int i = 0; i < 3; i++) begin
            rd_reg(addrs[i]);
            n_cmp++; if (readdatavalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rdv%0d got %b want 1", i, readdatavalid); end
            n_cmp++; if (readdata !== exp_rd) begin n_bad++; $display("FAIL b2b_data%0d got %h want %h", i, readdata, exp_rd); end
        end
        wr_reg(NR + 2, 4'hF, 32'hFFFF_FFFF);
        rd_reg(NR + 2);
        n_cmp++; if (readdata !== ID) begin n_bad++; $display("FAIL id_ro got %h want %h", readdata, ID); end
    endtask

    task automatic test_reset_midtransfer();
        wr_reg(0, 4'hF, 32'hA5A5_A5A5);
        wr_reg(NR + 1, 4'hF, 32'hFF);
        idle(8'h01);
        idle(8'h00);
        idle(8'h00);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        chipselect = 1; read = 1; address = 0;
        #3 resetn = 0;
        #1;
        n_cmp++; if ({readdata, readdatavalid, irq} !== 34'h0) begin n_bad++; $display("FAIL async_reset got %h/%b/%b want 0", readdata, readdatavalid, irq); end
        n_cmp++; if (Q_export !== {NR{32'h0}}) begin n_bad++; $display("FAIL async_reset_q got %h want 0", Q_export); end
        @(posedge clock); #1;
        n_cmp++; if (readdatavalid !== 1'b0) begin n_bad++; $display("FAIL aborted_read got %b want 0", readdatavalid); end
        chipselect = 0; read = 0; event_in = 0;
        resetn = 1;
        model_reset();
    endtask

    task automatic test_random();
        logic [7:0] ev;
        for (int i = 0; i < 400; i++) begin
            ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : event_in;
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                 4'($urandom), $urandom, ev);
            n_cmp++; if (readdatavalid !== exp_rdv) begin n_bad++; $display("FAIL rnd_rdv[%0d] got %b want %b", i, readdatavalid, exp_rdv); end
            n_cmp++; if (readdata !== exp_rd) begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", i, readdata, exp_rd); end
            n_cmp++; if (irq !== exp_irq) begin n_bad++; $display("FAIL rnd_irq[%0d] got %b want %b", i, irq, exp_irq); end
            n_cmp++; if (Q_export !== exp_q) begin n_bad++; $display("FAIL rnd_q[%0d] got %h want %h", i, Q_export, exp_q); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_rw_same();
        test_event_irq();
        test_collision();
        test_back_to_back();
        test_reset_midtransfer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
